// File: rtl/wbc_irq_pkg.sv
// rtl/wbc_irq_pkg.sv - shared level encodings, FSM states and BR-vs-PSW compare for wbc_irq_arb
package wbc_irq_pkg;

  localparam logic [1:0] BR4 = 2'd0;
  localparam logic [1:0] BR5 = 2'd1;
  localparam logic [1:0] BR6 = 2'd2;
  localparam logic [1:0] BR7 = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DROP
  } irq_state_t;

  // BRn maps to priority n (4..7); it gets through only when above the processor priority.
  function automatic logic br_eligible(input logic [1:0] lvl, input logic [2:0] psw);
    return ({1'b1, lvl} > psw);
  endfunction

endpackage

// File: rtl/wbc_rr_pick.sv
// rtl/wbc_rr_pick.sv - round-robin first-set finder: first req bit strictly after ptr, wrapping
module wbc_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // k = N wraps back onto ptr itself, so a lone requester at ptr is still found.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wbc_irq_arb.sv
// rtl/wbc_irq_arb.sv - BR4..BR7 priority/round-robin request scheduler in front of the vectored interrupt controller
// Optional grant watchdog and timeout_o port: define WBC_IRQ_ARB_WDOG_EN.
module wbc_irq_arb
  import wbc_irq_pkg::*;
#(
  parameter int             N         = 4,
  parameter logic [2*N-1:0] LEVELS    = '0,
  parameter logic [N-1:0]   EDGE_MASK = '0
`ifdef WBC_IRQ_ARB_WDOG_EN
  , parameter int           TIMEOUT   = 255
`endif
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [2:0]   psw_pri,
  input  logic [N-1:0] dev_req,
  output logic [N-1:0] dev_ack,
  output logic [N-1:0] vic_req,
  input  logic [N-1:0] vic_ack,
  output logic         busy_o
`ifdef WBC_IRQ_ARB_WDOG_EN
  , output logic       timeout_o
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  irq_state_t    state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  req_hist_q, req_hist_d;
  logic [N-1:0]  vic_req_q, vic_req_d;
  logic [N-1:0]  dev_ack_q, dev_ack_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;

  logic [N-1:0]  req, elig;
  logic [N-1:0]  lvl_req [4];
  logic [3:0]    lvl_found;
  logic [IW-1:0] lvl_idx [4];
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

`ifdef WBC_IRQ_ARB_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    req  = '0;
    elig = '0;
    for (int i = 0; i < N; i++) begin
      req[i]  = EDGE_MASK[i] ? pending_q[i] : dev_req[i];
      elig[i] = req[i] & br_eligible(LEVELS[2*i +: 2], psw_pri);
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lvl_req[l] = '0;
      for (int i = 0; i < N; i++) begin
        lvl_req[l][i] = elig[i] & (LEVELS[2*i +: 2] == 2'(l));
      end
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    wbc_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req   (lvl_req[l]),
      .ptr   (rr_ptr_q),
      .found (lvl_found[l]),
      .idx   (lvl_idx[l])
    );
  end

  // Ascending scan so the highest populated level overrides lower ones.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int l = 0; l < 4; l++) begin
      if (lvl_found[l]) begin
        pick_valid = 1'b1;
        pick_idx   = lvl_idx[l];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    vic_req_d = vic_req_q;
    dev_ack_d = '0;
    rr_ptr_d  = rr_ptr_q;
`ifdef WBC_IRQ_ARB_WDOG_EN
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        vic_req_d = '0;
        if (pick_valid) begin
          gnt_d               = pick_idx;
          vic_req_d[pick_idx] = 1'b1;
          state_d             = GRANT;
`ifdef WBC_IRQ_ARB_WDOG_EN
          wdog_d              = '0;
`endif
        end
      end
      GRANT: begin
        if (vic_ack[gnt_q]) begin
          dev_ack_d[gnt_q] = 1'b1;
          rr_ptr_d         = gnt_q;
          vic_req_d        = '0;
          state_d          = DROP;
        end else if (!elig[gnt_q]) begin
          vic_req_d = '0;
          state_d   = IDLE;
        end
`ifdef WBC_IRQ_ARB_WDOG_EN
        else if (wdog_q == WW'(TIMEOUT - 1)) begin
          vic_req_d = '0;
          timeout_d = 1'b1;
          rr_ptr_d  = gnt_q;
          state_d   = DROP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end
      DROP: begin
        vic_req_d = '0;
        state_d   = IDLE;
      end
      default: begin
        vic_req_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // A fresh edge landing on the acknowledge clock must survive the clear.
  always_comb begin
    req_hist_d = dev_req;
    pending_d  = EDGE_MASK & ((dev_req & ~req_hist_q) | (pending_q & ~dev_ack_d));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_hist_q <= '0;
      vic_req_q  <= '0;
      dev_ack_q  <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
`ifdef WBC_IRQ_ARB_WDOG_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_hist_q <= req_hist_d;
      vic_req_q  <= vic_req_d;
      dev_ack_q  <= dev_ack_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
`ifdef WBC_IRQ_ARB_WDOG_EN
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign vic_req = vic_req_q;
  assign dev_ack = dev_ack_q;
  assign busy_o  = (state_q != IDLE);
`ifdef WBC_IRQ_ARB_WDOG_EN
  assign timeout_o = timeout_q;
`endif

endmodule
